// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus for the execute stage: EX_* operands and controls in,
// MEM_* pipeline register contents and the front-end stall out.
interface ex_stage_if;
    logic [1:0]  EX_ctlwb;
    logic [2:0]  EX_ctlm;
    logic [3:0]  EX_ctlex;
    logic [31:0] EX_npc;
    logic [31:0] EX_rd1;
    logic [31:0] EX_rd2;
    logic [31:0] EX_imm;
    logic [4:0]  EX_rt;
    logic [4:0]  EX_rd;
    logic        ex_stall;
    logic [1:0]  MEM_ctlwb;
    logic [2:0]  MEM_ctlm;
    logic [31:0] MEM_btgt;
    logic        MEM_zero;
    logic [31:0] MEM_alu;
    logic [31:0] MEM_wdata;
    logic [4:0]  MEM_wreg;

    modport slave (
        input  EX_ctlwb, EX_ctlm, EX_ctlex, EX_npc, EX_rd1, EX_rd2, EX_imm, EX_rt, EX_rd,
        output ex_stall, MEM_ctlwb, MEM_ctlm, MEM_btgt, MEM_zero, MEM_alu, MEM_wdata, MEM_wreg
    );

    modport master (
        output EX_ctlwb, EX_ctlm, EX_ctlex, EX_npc, EX_rd1, EX_rd2, EX_imm, EX_rt, EX_rd,
        input  ex_stall, MEM_ctlwb, MEM_ctlm, MEM_btgt, MEM_zero, MEM_alu, MEM_wdata, MEM_wreg
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage with EX/MEM register. Define MULDIV_EN to include the
// iterative multu/divu unit with HI/LO; otherwise those functs retire as NOPs.
module ex_stage #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        r_type;
    logic        md_funct;
    logic        wb_kill;
    logic        stall;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [31:0] res;

    logic [1:0]  mem_ctlwb_q;
    logic [2:0]  mem_ctlm_q;
    logic [31:0] mem_btgt_q;
    logic        mem_zero_q;
    logic [31:0] mem_alu_q;
    logic [31:0] mem_wdata_q;
    logic [4:0]  mem_wreg_q;

    assign aluop    = bus.EX_ctlex[2:1];
    assign funct    = bus.EX_imm[5:0];
    assign r_type   = (aluop == 2'b10);
    assign md_funct = r_type && ((funct == 6'h19) || (funct == 6'h1B));
    assign op_b     = bus.EX_ctlex[0] ? bus.EX_imm : bus.EX_rd2;
    assign sum      = bus.EX_rd1 + op_b;

`ifdef MULDIV_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  st_q, st_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] p_q, p_d;
    logic [31:0] a_q, a_d;
    logic        isdiv_q, isdiv_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [32:0] mul_sum;
    logic [63:0] mul_p;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_r;
    logic [63:0] div_p;
    logic [63:0] step_p;

    // Multiply: {acc, multiplier} shifts right, adding the multiplicand into
    // the upper half on each 1 bit. Divide: {rem, quot} shifts left, restoring.
    assign mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_p   = {mul_sum, p_q[31:1]};
    assign div_sh  = {p_q[63:32], p_q[31]};
    assign div_ge  = (div_sh >= {1'b0, a_q});
    assign div_r   = div_ge ? (div_sh[31:0] - a_q) : div_sh[31:0];
    assign div_p   = {div_r, p_q[30:0], div_ge};
    assign step_p  = isdiv_q ? div_p : mul_p;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (st_q)
            ST_IDLE: begin
                if (md_funct) begin
                    p_d     = {32'd0, bus.EX_rd1};
                    a_d     = bus.EX_rd2;
                    isdiv_d = (funct == 6'h1B);
                    cnt_d   = 5'd0;
                    st_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                p_d   = step_p;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d = step_p[63:32];
                    lo_d = (isdiv_q && (a_q == 32'd0)) ? DIV0_LO : step_p[31:0];
                    st_d = ST_DONE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            cnt_q   <= 5'd0;
            p_q     <= 64'd0;
            a_q     <= 32'd0;
            isdiv_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Gated by rst so the stall drops the moment reset is applied.
    assign stall   = !rst && (((st_q == ST_IDLE) && md_funct) || (st_q == ST_BUSY));
    assign wb_kill = md_funct;
`else
    logic hilo_funct;

    assign hilo_funct = r_type && ((funct == 6'h10) || (funct == 6'h12));
    assign stall      = 1'b0;
    assign wb_kill    = md_funct || hilo_funct;
`endif

    always_comb begin
        res = sum;
        case (aluop)
            2'b01: res = bus.EX_rd1 - op_b;
            2'b10: begin
                case (funct)
                    6'h22: res = bus.EX_rd1 - op_b;
                    6'h24: res = bus.EX_rd1 & op_b;
                    6'h25: res = bus.EX_rd1 | op_b;
                    6'h2A: res = {31'd0, ($signed(bus.EX_rd1) < $signed(op_b))};
`ifdef MULDIV_EN
                    6'h10: res = hi_q;
                    6'h12: res = lo_q;
`endif
                    default: res = sum;
                endcase
            end
            default: res = sum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ctlwb_q <= 2'd0;
            mem_ctlm_q  <= 3'd0;
            mem_btgt_q  <= 32'd0;
            mem_zero_q  <= 1'b0;
            mem_alu_q   <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wreg_q  <= 5'd0;
        end else begin
            mem_ctlwb_q <= stall ? 2'd0 : {bus.EX_ctlwb[1] & ~wb_kill, bus.EX_ctlwb[0]};
            mem_ctlm_q  <= stall ? 3'd0 : bus.EX_ctlm;
            mem_btgt_q  <= bus.EX_npc + {bus.EX_imm[29:0], 2'b00};
            mem_zero_q  <= (res == 32'd0);
            mem_alu_q   <= res;
            mem_wdata_q <= bus.EX_rd2;
            mem_wreg_q  <= bus.EX_ctlex[3] ? bus.EX_rd : bus.EX_rt;
        end
    end

    assign bus.ex_stall  = stall;
    assign bus.MEM_ctlwb = mem_ctlwb_q;
    assign bus.MEM_ctlm  = mem_ctlm_q;
    assign bus.MEM_btgt  = mem_btgt_q;
    assign bus.MEM_zero  = mem_zero_q;
    assign bus.MEM_alu   = mem_alu_q;
    assign bus.MEM_wdata = mem_wdata_q;
    assign bus.MEM_wreg  = mem_wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; multiply/divide cases run when MULDIV_EN is defined.
module tb_ex_stage;

    logic clk;
    logic rst;
    ex_stage_if bus();

    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] btgt;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        bit          data_valid;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_hi = 32'd0;
    logic [31:0] tb_lo = 32'd0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                                   input logic [31:0] npc, input logic [31:0] rd1,
                                   input logic [31:0] rd2, input logic [31:0] imm,
                                   input logic [4:0] rt, input logic [4:0] rd);
        exp_t        e;
        logic [31:0] b;
        logic [31:0] r;
        bit          nop;
        b   = ex[0] ? imm : rd2;
        r   = rd1 + b;
        nop = 1'b0;
        if (ex[2:1] == 2'b01) r = rd1 - b;
        if (ex[2:1] == 2'b10) begin
            case (imm[5:0])
                6'h22: r = rd1 - b;
                6'h24: r = rd1 & b;
                6'h25: r = rd1 | b;
                6'h2A: r = ($signed(rd1) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MULDIV_EN
                6'h10: r = tb_hi;
                6'h12: r = tb_lo;
`else
                6'h10, 6'h12: nop = 1'b1;
`endif
                6'h19, 6'h1B: nop = 1'b1;
                default: ;
            endcase
        end
        e.wb         = nop ? {1'b0, wb[0]} : wb;
        e.m          = m;
        e.btgt       = npc + {imm[29:0], 2'b00};
        e.zero       = (r == 32'd0);
        e.alu        = r;
        e.wdata      = rd2;
        e.wreg       = ex[3] ? rd : rt;
        e.data_valid = 1'b1;
        return e;
    endfunction

    task automatic apply(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
        bus.EX_ctlwb = wb;
        bus.EX_ctlm  = m;
        bus.EX_ctlex = ex;
        bus.EX_npc   = npc;
        bus.EX_rd1   = rd1;
        bus.EX_rd2   = rd2;
        bus.EX_imm   = imm;
        bus.EX_rt    = rt;
        bus.EX_rd    = rd;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, ".sbq"}, 64'd1, 64'd0);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".ctlwb"}, 64'(bus.MEM_ctlwb), 64'(e.wb));
        chk({tag, ".ctlm"}, 64'(bus.MEM_ctlm), 64'(e.m));
        if (e.data_valid) begin
            chk({tag, ".btgt"}, 64'(bus.MEM_btgt), 64'(e.btgt));
            chk({tag, ".zero"}, 64'(bus.MEM_zero), 64'(e.zero));
            chk({tag, ".alu"}, 64'(bus.MEM_alu), 64'(e.alu));
            chk({tag, ".wdata"}, 64'(bus.MEM_wdata), 64'(e.wdata));
            chk({tag, ".wreg"}, 64'(bus.MEM_wreg), 64'(e.wreg));
        end
        $display("txn %s ctlwb=%b ctlm=%b alu=%h zero=%b wreg=%0d btgt=%h",
                 tag, bus.MEM_ctlwb, bus.MEM_ctlm, bus.MEM_alu, bus.MEM_zero,
                 bus.MEM_wreg, bus.MEM_btgt);
    endtask

    // Single-cycle instruction: called 1 time unit after a rising edge.
    task automatic do_op(input string tag, input logic [1:0] wb, input logic [2:0] m,
                         input logic [3:0] ex, input logic [31:0] npc, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [4:0] rt, input logic [4:0] rd);
        apply(wb, m, ex, npc, rd1, rd2, imm, rt, rd);
        sbq.push_back(model(wb, m, ex, npc, rd1, rd2, imm, rt, rd));
        #1;
        chk({tag, ".stall"}, 64'(bus.ex_stall), 64'd0);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

`ifdef MULDIV_EN
    task automatic run_md(input string tag, input bit isdiv, input logic [31:0] a,
                          input logic [31:0] b);
        exp_t        bub;
        int          stalls;
        logic [63:0] prod;
        apply(2'b10, 3'b000, 4'b1100, 32'h40, a, b, isdiv ? 32'h1B : 32'h19, 5'd3, 5'd4);
        bub.wb = 2'b00; bub.m = 3'b000; bub.data_valid = 1'b0;
        bub.btgt = '0; bub.zero = 1'b0; bub.alu = '0; bub.wdata = '0; bub.wreg = '0;
        #1;
        stalls = 0;
        for (int i = 0; i < 40 && bus.ex_stall; i++) begin
            stalls++;
            sbq.push_back(bub);
            @(posedge clk);
            #1;
            pop_check($sformatf("%s.bubble%0d", tag, i));
        end
        chk({tag, ".stall_cycles"}, 64'(stalls), 64'd33);
        sbq.push_back(bub);
        @(posedge clk);
        #1;
        pop_check({tag, ".retire"});
        if (isdiv) begin
            tb_lo = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            tb_hi = (b == 32'd0) ? a : a % b;
        end else begin
            prod  = {32'd0, a} * {32'd0, b};
            tb_hi = prod[63:32];
            tb_lo = prod[31:0];
        end
    endtask
`endif

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        apply(2'b11, 3'b111, 4'b1111, 32'h1234, 32'h55, 32'h66, 32'h77, 5'd7, 5'd8);
        repeat (2) @(posedge clk);
        #1;
        chk("rst0.ctlwb", 64'(bus.MEM_ctlwb), 64'd0);
        chk("rst0.alu", 64'(bus.MEM_alu), 64'd0);
        rst = 1'b0;

        do_op("add_rr", 2'b10, 3'b000, 4'b1100, 32'h10, 32'd7, 32'd9, 32'h20, 5'd1, 5'd2);
        // Reset pulse in mid-cycle with live inputs: outputs clear without waiting for an edge.
        #3;
        rst = 1'b1;
        #1;
        chk("rst1.ctlwb", 64'(bus.MEM_ctlwb), 64'd0);
        chk("rst1.ctlm", 64'(bus.MEM_ctlm), 64'd0);
        chk("rst1.btgt", 64'(bus.MEM_btgt), 64'd0);
        chk("rst1.zero", 64'(bus.MEM_zero), 64'd0);
        chk("rst1.alu", 64'(bus.MEM_alu), 64'd0);
        chk("rst1.wdata", 64'(bus.MEM_wdata), 64'd0);
        chk("rst1.wreg", 64'(bus.MEM_wreg), 64'd0);
        chk("rst1.stall", 64'(bus.ex_stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op("sub_zero", 2'b10, 3'b000, 4'b1100, 32'h20, 32'd5, 32'd5, 32'h22, 5'd3, 5'd9);
        do_op("lw_btgt", 2'b11, 3'b100, 4'b0001, 32'h100, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd6, 5'd0);
        do_op("slt", 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd0, 5'd11);
        do_op("and", 2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h24, 5'd0, 5'd12);
        do_op("or", 2'b10, 3'b000, 4'b1100, 32'h0, 32'hF000_0001, 32'h0000_0F00, 32'h25, 5'd0, 5'd13);
        do_op("beq_sub", 2'b00, 3'b100, 4'b0010, 32'h8000_0000, 32'd3, 32'd4, 32'h0000_0010, 5'd1, 5'd2);
        do_op("sw_add", 2'b00, 3'b001, 4'b0111, 32'h44, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'd4, 5'd5, 5'd6);
        do_op("funct_dflt", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd20, 32'd22, 32'h3F, 5'd0, 5'd14);

`ifdef MULDIV_EN
        run_md("multu", 1'b0, 32'hFFFF_FFFF, 32'd2);
        do_op("mfhi_mul", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd9, 32'd9, 32'h10, 5'd0, 5'd15);
        do_op("mflo_mul", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd9, 32'd9, 32'h12, 5'd0, 5'd16);
        chk("multu.hi_model", 64'(tb_hi), 64'd1);
        run_md("divu", 1'b1, 32'd100, 32'd7);
        do_op("mfhi_div", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd1, 32'h10, 5'd0, 5'd17);
        do_op("mflo_div", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd1, 32'h12, 5'd0, 5'd18);
        run_md("divu0", 1'b1, 32'd100, 32'd0);
        do_op("mfhi_div0", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd1, 32'h10, 5'd0, 5'd19);
        do_op("mflo_div0", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd1, 32'h12, 5'd0, 5'd20);

        // Abort a multu ten BUSY cycles in: HI/LO must stay at their reset value.
        apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h19, 5'd0, 5'd0);
        repeat (11) @(posedge clk);
        #3;
        chk("abort.stall_before", 64'(bus.ex_stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort.stall", 64'(bus.ex_stall), 64'd0);
        chk("abort.ctlwb", 64'(bus.MEM_ctlwb), 64'd0);
        tb_hi = 32'd0;
        tb_lo = 32'd0;
        apply(2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op("abort.mfhi", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd4, 32'h10, 5'd0, 5'd21);
        do_op("abort.mflo", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd4, 32'h12, 5'd0, 5'd22);
`else
        do_op("multu_nop", 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h19, 5'd0, 5'd15);
        do_op("divu_nop", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd100, 32'd7, 32'h1B, 5'd0, 5'd16);
        do_op("mfhi_nop", 2'b11, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd4, 32'h10, 5'd0, 5'd17);
        do_op("mflo_nop", 2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'hFFFF_FFFB, 32'h12, 5'd0, 5'd18);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
